// File: rtl/game_datapath.sv
// game_datapath
// Datapath and state for a one-button runner game. A game FSM (IDLE/RUN/DEAD)
// gates a player jump FSM and a scrolling obstacle. All motion advances only on
// frame ticks, and every output comes straight from a register.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   start      one-cycle pulse: begin or restart a game (overrides collision/tick)
//   tick       one-cycle frame enable
//   jump       debounced button level, latched while a game runs
//   endgame    one-cycle pulse on the first DEAD cycle after a collision
//   running    high while the game FSM is in RUN
//   player_y   player height above ground
//   obstacle_x obstacle left column
//   score      obstacles cleared, saturating at 255
//
// game FSM:
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   RUN     | game in progress, motion on tick
//   DEAD    | collision happened, outputs frozen until start
// player FSM:
//   state   | meaning
//   GROUND  | on the ground, a latched jump launches on the next tick
//   RISING  | climbing one row per tick up to the apex
//   FALLING | descending one row per tick back to the ground
module game_datapath #(
   parameter int SCREEN_W = 160,
   parameter int PLAYER_X = 16,
   parameter int OBS_W    = 4,
   parameter int OBS_H    = 8,
   parameter int JUMP_H   = 24,
   parameter int SPEED    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       tick,
   input  logic       jump,
   output logic       endgame,
   output logic       running,
   output logic [6:0] player_y,
   output logic [7:0] obstacle_x,
   output logic [7:0] score
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} game_t;
   typedef enum logic [1:0] {P_GROUND, P_RISING, P_FALLING} player_t;

   localparam logic [7:0] SPAWN_X  = 8'(SCREEN_W - 1);
   localparam logic [7:0] STEP_X   = 8'(SPEED);
   localparam logic [6:0] APEX_Y   = 7'(JUMP_H);
   localparam logic [6:0] HIGH_Y   = 7'(OBS_H);
   localparam logic [8:0] PLAYER_C = 9'(PLAYER_X);
   localparam logic [8:0] OBS_SPAN = 9'(OBS_W - 1);

   game_t      state, state_n;
   player_t    pstate, pstate_n;
   logic       latch, latch_n;
   logic       endgame_n;
   logic [6:0] player_y_n;
   logic [7:0] obstacle_x_n;
   logic [7:0] score_n;
   logic       collide;
   logic [8:0] obs_right;

   // Obstacle right edge in 9 bits so the overlap test cannot wrap.
   assign obs_right = {1'b0, obstacle_x} + OBS_SPAN;
   assign collide   = (state == S_RUN) && (PLAYER_C <= obs_right) &&
                      ({1'b0, obstacle_x} <= PLAYER_C) && (player_y < HIGH_Y);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         pstate     <= P_GROUND;
         latch      <= 1'b0;
         endgame    <= 1'b0;
         running    <= 1'b0;
         player_y   <= '0;
         obstacle_x <= SPAWN_X;
         score      <= '0;
      end else begin
         state      <= state_n;
         pstate     <= pstate_n;
         latch      <= latch_n;
         endgame    <= endgame_n;
         running    <= (state_n == S_RUN);
         player_y   <= player_y_n;
         obstacle_x <= obstacle_x_n;
         score      <= score_n;
      end
   end

   always_comb begin
      state_n      = state;
      pstate_n     = pstate;
      latch_n      = latch;
      endgame_n    = 1'b0;
      player_y_n   = player_y;
      obstacle_x_n = obstacle_x;
      score_n      = score;

      if (start) begin
         // Start beats both a coincident collision and a coincident tick.
         state_n      = S_RUN;
         pstate_n     = P_GROUND;
         latch_n      = 1'b0;
         player_y_n   = '0;
         obstacle_x_n = SPAWN_X;
         score_n      = '0;
      end else if (state == S_RUN) begin
         if (collide) begin
            // Motion is frozen on the collision cycle so DEAD shows the hit.
            state_n   = S_DEAD;
            endgame_n = 1'b1;
         end else begin
            if (tick) begin
               unique case (pstate)
                  P_GROUND: begin
                     if (latch) begin
                        pstate_n   = P_RISING;
                        player_y_n = 7'd1;
                        latch_n    = 1'b0;
                     end
                  end
                  P_RISING: begin
                     player_y_n = player_y + 7'd1;
                     if (player_y + 7'd1 == APEX_Y) pstate_n = P_FALLING;
                  end
                  P_FALLING: begin
                     player_y_n = player_y - 7'd1;
                     if (player_y == 7'd1) pstate_n = P_GROUND;
                  end
                  default: pstate_n = P_GROUND;
               endcase

               if (obstacle_x < STEP_X) begin
                  obstacle_x_n = SPAWN_X;
                  score_n      = (score == 8'hFF) ? score : score + 8'd1;
               end else begin
                  obstacle_x_n = obstacle_x - STEP_X;
               end
            end
            // A press on a consuming tick re-arms the latch for the next jump.
            if (jump) latch_n = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_game_datapath.sv
// tb_game_datapath
// Scoreboard bench for game_datapath. A driver applies one input vector per
// cycle, advances a behavioural game model and queues the outputs expected
// after the next edge; a monitor pops and compares them every cycle.
// Ports of the DUT are all driven/observed here; no ports of its own.
module tb_game_datapath;

   localparam int SW = 160, PX = 16, OW = 4, OH = 8, JH = 24, SP = 2;

   logic       clk, reset, start, tick, jump;
   logic       endgame, running;
   logic [6:0] player_y;
   logic [7:0] obstacle_x, score;

   game_datapath #(
      .SCREEN_W(SW), .PLAYER_X(PX), .OBS_W(OW), .OBS_H(OH), .JUMP_H(JH), .SPEED(SP)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .tick(tick), .jump(jump),
      .endgame(endgame), .running(running), .player_y(player_y),
      .obstacle_x(obstacle_x), .score(score)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic       endgame;
      logic       running;
      logic [6:0] y;
      logic [7:0] x;
      logic [7:0] score;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model: mode 0=idle 1=playing 2=over; air = ticks since take-off (0 = grounded).
   int m_mode, m_air, m_x, m_score;
   bit m_pend, m_end;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int height();
      if (m_air == 0) return 0;
      if (m_air <= JH) return m_air;
      return 2 * JH - m_air;
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_air = 0; m_pend = 0; m_x = SW - 1; m_score = 0; m_end = 0;
   endfunction

   function automatic void model_step(bit s, bit t, bit j);
      bit hit;
      m_end = 0;
      if (s) begin
         m_mode = 1; m_air = 0; m_pend = 0; m_x = SW - 1; m_score = 0;
      end else if (m_mode == 1) begin
         hit = (m_x + OW - 1 >= PX) && (m_x <= PX) && (height() < OH);
         if (hit) begin
            m_mode = 2;
            m_end  = 1;
         end else begin
            if (t) begin
               if (m_air > 0) begin
                  m_air++;
                  if (m_air == 2 * JH) m_air = 0;
               end else if (m_pend) begin
                  m_air  = 1;
                  m_pend = 0;
               end
               if (m_x < SP) begin
                  m_x = SW - 1;
                  if (m_score < 255) m_score++;
               end else begin
                  m_x = m_x - SP;
               end
            end
            if (j) m_pend = 1;
         end
      end
   endfunction

   task automatic step(bit s, bit t, bit j);
      exp_t e;
      @(negedge clk);
      start = s; tick = t; jump = j;
      model_step(s, t, j);
      e.endgame = m_end;
      e.running = (m_mode == 1);
      e.y       = 7'(height());
      e.x       = 8'(m_x);
      e.score   = 8'(m_score);
      q.push_back(e);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset_values(string tag);
      check({tag, "_endgame"}, 32'(endgame), 0);
      check({tag, "_running"}, 32'(running), 0);
      check({tag, "_player_y"}, 32'(player_y), 0);
      check({tag, "_obstacle_x"}, 32'(obstacle_x), SW - 1);
      check({tag, "_score"}, 32'(score), 0);
   endtask

   // Monitor: every cycle is an output beat once reset is released.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && q.size() > 0) begin
            e = q.pop_front();
            check("sb_endgame", 32'(endgame), 32'(e.endgame));
            check("sb_running", 32'(running), 32'(e.running));
            check("sb_player_y", 32'(player_y), 32'(e.y));
            check("sb_obstacle_x", 32'(obstacle_x), 32'(e.x));
            check("sb_score", 32'(score), 32'(e.score));
         end
      end
   end

   initial begin
      bit s;
      reset = 1'b1; start = 1'b0; tick = 1'b0; jump = 1'b0;
      model_reset();
      #2;
      check_reset_values("por");
      @(negedge clk);
      reset = 1'b0;

      // Idle: ticks and jumps do nothing.
      step(0, 0, 0);
      step(0, 1, 1);
      step(0, 1, 0);

      // Start then 10 plain ticks.
      step(1, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 0);
      settle();
      check("ten_ticks_x", 32'(obstacle_x), 139);
      check("ten_ticks_y", 32'(player_y), 0);
      check("ten_ticks_score", 32'(score), 0);
      check("ten_ticks_running", 32'(running), 1);

      // Full jump arc: apex after 24 ticks, ground after 48.
      step(0, 0, 1);
      for (int i = 0; i < 24; i++) step(0, 1, 0);
      settle();
      check("apex_y", 32'(player_y), JH);
      for (int i = 0; i < 24; i++) step(0, 1, 0);
      settle();
      check("landed_y", 32'(player_y), 0);
      step(0, 1, 0);
      settle();
      check("grounded_y", 32'(player_y), 0);

      // No jump: hit at x=15 after tick 72, then frozen in DEAD.
      step(1, 0, 0);
      for (int i = 0; i < 72; i++) step(0, 1, 0);
      settle();
      check("pre_hit_x", 32'(obstacle_x), 15);
      check("pre_hit_endgame", 32'(endgame), 0);
      step(0, 1, 0);
      settle();
      check("hit_endgame", 32'(endgame), 1);
      check("hit_running", 32'(running), 0);
      check("hit_x", 32'(obstacle_x), 15);
      for (int i = 0; i < 4; i++) step(0, 1, 1);
      settle();
      check("dead_endgame", 32'(endgame), 0);
      check("dead_x", 32'(obstacle_x), 15);

      // Jump over the obstacle; it wraps to 159 with score 1.
      step(1, 0, 0);
      for (int i = 1; i <= 80; i++) step(0, 1, i == 59);
      settle();
      check("clear_x", 32'(obstacle_x), SW - 1);
      check("clear_score", 32'(score), 1);
      check("clear_running", 32'(running), 1);

      // Start on the collision cycle wins.
      step(1, 0, 0);
      for (int i = 0; i < 72; i++) step(0, 1, 0);
      step(1, 1, 0);
      settle();
      check("restart_endgame", 32'(endgame), 0);
      check("restart_running", 32'(running), 1);
      check("restart_x", 32'(obstacle_x), SW - 1);
      step(0, 0, 0);
      settle();
      check("restart_no_pulse", 32'(endgame), 0);

      // Asynchronous reset while rising.
      step(0, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 0);
      settle();
      check("pre_reset_y", 32'(player_y), 5);
      #1;
      reset = 1'b1;
      #1;
      check_reset_values("async");
      model_reset();
      q.delete();
      start = 1'b0; tick = 1'b0; jump = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(0, 1, 0);
      step(1, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 0);
      settle();
      check("post_reset_x", 32'(obstacle_x), 139);
      check("post_reset_y", 32'(player_y), 0);

      // Clear 258 obstacles in a row: score saturates at 255.
      step(1, 0, 0);
      for (int c = 0; c < 258; c++)
         for (int i = 1; i <= 80; i++) step(0, 1, i == 59);
      settle();
      check("sat_score", 32'(score), 255);
      check("sat_running", 32'(running), 1);

      // Random play.
      for (int n = 0; n < 4000; n++) begin
         s = (m_mode == 1) ? ($urandom_range(0, 599) == 0) : ($urandom_range(0, 9) == 0);
         step(s, 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
      end

      step(0, 0, 0);
      settle();
      settle();
      check("queue_drained", 32'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/game_datapath.md
GAME_DATAPATH -- requirements
Module: game_datapath

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SCREEN_W, 160, obstacle spawn column + 1
- PLAYER_X, 16, fixed player column
- OBS_W, 4, obstacle width in columns
- OBS_H, 8, obstacle height in rows
- JUMP_H, 24, apex height of a jump
- SPEED, 2, obstacle columns moved per tick
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, system clock
- reset, in, 1, asynchronous active-high reset
- start, in, 1, one-cycle pulse from the control FSM; begins or restarts a game
- tick, in, 1, one-cycle frame enable; all motion advances only on tick
- jump, in, 1, level from the user button (already debounced)
- endgame, out, 1, one-cycle pulse to the control FSM on collision
- running, out, 1, high while a game is in progress
- player_y, out, 7, player height above ground
- obstacle_x, out, 8, obstacle left column
- score, out, 8, obstacles cleared, saturating

Function
REQ-003 Game FSM states: IDLE, RUN, DEAD; running SHALL be 1 only in RUN.
REQ-004 IDLE/DEAD --start--> RUN; RUN --collision--> DEAD; RUN --start--> RUN with full re-initialisation.
REQ-005 On entering RUN: player_y=0, obstacle_x=SCREEN_W-1, score=0, player FSM=GROUND, jump latch cleared.
REQ-006 Player FSM states: GROUND, RISING, FALLING; advances only on cycles with tick=1 in RUN.
REQ-007 Jump latch: set by jump=1 on any RUN cycle; cleared when consumed on a tick or on entry to RUN; ignored outside RUN.
REQ-008 GROUND on tick with latch set -> RISING, player_y becomes 1, latch cleared; tick with latch clear -> no change.
REQ-009 RISING on tick: player_y+1; when player_y reaches JUMP_H, go to FALLING on that same tick.
REQ-010 FALLING on tick: player_y-1; when player_y reaches 0, go to GROUND on that same tick; jumps latched during RISING/FALLING stay pending until GROUND.
REQ-011 Obstacle on tick: if obstacle_x < SPEED, obstacle_x = SCREEN_W-1 and score += 1 (saturating at 255); otherwise obstacle_x -= SPEED; obstacle_x never wraps below 0.
REQ-012 Collision (combinational on current registers, RUN only): PLAYER_X <= obstacle_x + OBS_W - 1 and obstacle_x <= PLAYER_X and player_y < OBS_H.
REQ-013 A collision in RUN SHALL move the FSM to DEAD on the next edge; position and score updates are suppressed on that cycle even if tick=1.
REQ-014 endgame SHALL be registered: high exactly one cycle, the cycle after the RUN->DEAD edge; it is never asserted in any other case.
REQ-015 In DEAD, player_y, obstacle_x and score hold their final values until start.
REQ-016 If start and collision coincide in RUN, start wins: re-initialise and no endgame pulse.
REQ-017 If start and tick coincide, initialisation wins and the tick is discarded.
REQ-018 All outputs SHALL be registered; latency from tick to updated outputs is 1 cycle.

Reset
REQ-019 reset=1 SHALL immediately (asynchronously) force FSM=IDLE, player FSM=GROUND, latch=0, endgame=0, running=0, player_y=0, obstacle_x=SCREEN_W-1, score=0.
REQ-020 Reset mid-game SHALL abandon the game with no endgame pulse; operation resumes on the first clock edge after reset is released, in IDLE.

Verification
REQ-021 Reset, then start, then 10 ticks with jump=0 -> obstacle_x=139, player_y=0, score=0, running=1.
REQ-022 jump pulse in RUN, then 24 ticks -> player_y=24 and FALLING; 24 more ticks -> player_y=0 and GROUND; total 48 ticks airborne.
REQ-023 No jump from start -> collision when obstacle_x=15 (tick 72); endgame high exactly 1 cycle; state DEAD; obstacle_x holds at 15.
REQ-024 Jump timed so player_y>=8 while obstacle_x is in 13..16 -> no endgame; obstacle wraps at obstacle_x=1 to 159 and score=1.
REQ-025 start asserted on the same cycle as a collision -> no endgame pulse, outputs re-initialised per REQ-005.
REQ-026 reset pulsed asynchronously (between clock edges) during RISING -> outputs at reset values before the next edge; a later start begins a clean game.
